// File: rtl/uart_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_ctrl_if
// Host (Nios-side) register bus used to access the UART controller.
//   address   [2:0]  register select
//   write            write strobe, one cycle per access
//   writedata [7:0]  write data
//   read             read strobe, one cycle per access
//   readdata  [7:0]  registered read data
// Modports: master = host side, slave = controller side.
// ----------------------------------------------------------------------------
interface uart_ctrl_if;
    logic [2:0] address;
    logic       write;
    logic [7:0] writedata;
    logic       read;
    logic [7:0] readdata;

    modport master (output address, write, writedata, read, input readdata);
    modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/uart_ctrl.sv
// ----------------------------------------------------------------------------
// uart_ctrl
// Register-mapped controller between the host bus and the UART datapath.
// Holds the configuration word, buffers outgoing bytes in a TX FIFO, sequences
// the sender one byte at a time, and captures received bytes for the host.
//
// Ports:
//   sys_clk, reset        clock and synchronous active-high reset
//   bus (slave)           host register bus (see uart_ctrl_if)
//   irq                   level interrupt (registered)
//   cfg_options[7:0]      configuration word to the UART datapath
//   tx_data[7:0]          byte presented to the sender
//   tx_start / tx_done    sender handshake; tx_start held until tx_done
//   rx_data, rx_parity_ok received byte and its parity status
//   rx_ready, rx_busy     receiver byte-valid pulse and mid-frame flag
//   rx_ack                one-cycle acknowledge to the receiver
//   cts_n                 clear-to-send, active low (only with UART_CTS_EN)
//
// Optional feature macro: UART_CTS_EN. When defined, transmission waits for
// cts_n=0, STATUS bit7 shows cts and tx_ovf moves to IRQ_EN bit7 (read-only).
// ----------------------------------------------------------------------------
module uart_ctrl #(
    parameter int         TX_DEPTH   = 8,
    parameter int         GAP_CYCLES = 16,
    parameter logic [7:0] CFG_RESET  = 8'b11000000
) (
    input  logic            sys_clk,
    input  logic            reset,
    uart_ctrl_if.slave      bus,
    output logic            irq,
    output logic [7:0]      cfg_options,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_done,
    input  logic [7:0]      rx_data,
    input  logic            rx_parity_ok,
    input  logic            rx_ready,
    input  logic            rx_busy,
`ifdef UART_CTS_EN
    input  logic            cts_n,
`endif
    output logic            rx_ack
);

    localparam int AW       = $clog2(TX_DEPTH);
    localparam int GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // The cycle IDLE spends popping the next byte is the last gap cycle, so
    // GAP itself lasts GAP_CYCLES-1 cycles and tx_start stays low GAP_CYCLES.
    localparam int GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [7:0]    mem [TX_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    ptr_t          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t          count_q, count_d;
    logic [7:0]    cfg_q, cfg_d, tx_data_q, tx_data_d, rx_hold_q, rx_hold_d;
    logic [7:0]    readdata_q, readdata_d;
    logic          tx_start_q, tx_start_d, rx_valid_q, rx_valid_d;
    logic          parity_err_q, parity_err_d, rx_ovr_q, rx_ovr_d;
    logic          tx_ovf_q, tx_ovf_d, cfg_err_q, cfg_err_d;
    logic          ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
    logic          irq_q, irq_d, rx_ack_q, rx_ack_d;

    logic       tx_empty, tx_full, tx_busy, cts_ok, pop, push_ok;
    logic       wr_cfg, wr_stat, wr_txd, wr_ien, rd_rxd;
    logic [7:0] status, ien_rd, rd_val;

`ifdef UART_CTS_EN
    assign cts_ok = ~cts_n;
    assign status = {~cts_n, cfg_err_q, rx_ovr_q, parity_err_q,
                     tx_busy, tx_full, tx_empty, rx_valid_q};
    assign ien_rd = {tx_ovf_q, 5'b0, ie_tx_q, ie_rx_q};
`else
    assign cts_ok = 1'b1;
    assign status = {tx_ovf_q, cfg_err_q, rx_ovr_q, parity_err_q,
                     tx_busy, tx_full, tx_empty, rx_valid_q};
    assign ien_rd = {6'b0, ie_tx_q, ie_rx_q};
`endif

    assign tx_empty = (count_q == '0);
    assign tx_full  = (count_q == cnt_t'(TX_DEPTH));
    assign tx_busy  = (state_q != ST_IDLE);
    assign wr_cfg   = bus.write && (bus.address == 3'd0);
    assign wr_stat  = bus.write && (bus.address == 3'd1);
    assign wr_txd   = bus.write && (bus.address == 3'd2);
    assign wr_ien   = bus.write && (bus.address == 3'd4);
    assign rd_rxd   = bus.read  && (bus.address == 3'd3);
    // Fullness is judged before any same-cycle pop: a push into a full FIFO
    // is always dropped.
    assign push_ok  = wr_txd && !tx_full;
    assign pop      = (state_q == ST_IDLE) && !tx_empty && cts_ok;

    always_comb begin
        case (bus.address)
            3'd0:    rd_val = cfg_q;
            3'd1:    rd_val = status;
            3'd3:    rd_val = rx_hold_q;
            3'd4:    rd_val = ien_rd;
            default: rd_val = 8'h00;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned;
        // that is what keeps this block free of inferred latches.
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cfg_d        = cfg_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = tx_start_q;
        rx_hold_d    = rx_hold_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        rx_ovr_d     = rx_ovr_q;
        tx_ovf_d     = tx_ovf_q;
        cfg_err_d    = cfg_err_q;
        ie_rx_d      = ie_rx_q;
        ie_tx_d      = ie_tx_q;
        readdata_d   = bus.read ? rd_val : readdata_q;
        rx_ack_d     = rx_ready;
        irq_d        = (rx_valid_q & ie_rx_q) | (tx_empty & ~tx_busy & ie_tx_q);

        // Register writes; flag clears come first so same-cycle sets win.
        if (wr_cfg) begin
            if ((state_q == ST_IDLE) && tx_empty && !tx_start_q && !rx_busy)
                cfg_d = bus.writedata;
            else
                cfg_err_d = 1'b1;
        end
        if (wr_stat) begin
            if (bus.writedata[7]) tx_ovf_d  = 1'b0;
            if (bus.writedata[6]) cfg_err_d = 1'b0;
            if (bus.writedata[5]) rx_ovr_d  = 1'b0;
        end
        if (wr_ien) begin
            ie_rx_d = bus.writedata[0];
            ie_tx_d = bus.writedata[1];
        end
        if (wr_txd && tx_full) tx_ovf_d = 1'b1;
        if (push_ok)           wr_ptr_d = wr_ptr_q + ptr_t'(1);

        // RX holding register; a read in the same cycle frees the slot.
        if (rd_rxd) rx_valid_d = 1'b0;
        if (rx_ready) begin
            if (!rx_valid_q || rd_rxd) begin
                rx_hold_d    = rx_data;
                parity_err_d = ~rx_parity_ok;
                rx_valid_d   = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: if (pop) begin
                tx_data_d  = mem[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: if (tx_done) begin
                tx_start_d = 1'b0;
                gap_cnt_d  = GW'(GAP_LOAD);
                state_d    = (GAP_CYCLES <= 1) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (push_ok && !pop)      count_d = count_q + cnt_t'(1);
        else if (!push_ok && pop) count_d = count_q - cnt_t'(1);
    end

    // NOTE: FIFO storage has no reset; emptiness is tracked by the pointers
    // and count, so stale contents are never observed.
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.writedata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cfg_q        <= CFG_RESET;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            rx_hold_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            rx_ovr_q     <= 1'b0;
            tx_ovf_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
            ie_rx_q      <= 1'b0;
            ie_tx_q      <= 1'b0;
            readdata_q   <= 8'h00;
            irq_q        <= 1'b0;
            rx_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cfg_q        <= cfg_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            rx_hold_q    <= rx_hold_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            rx_ovr_q     <= rx_ovr_d;
            tx_ovf_q     <= tx_ovf_d;
            cfg_err_q    <= cfg_err_d;
            ie_rx_q      <= ie_rx_d;
            ie_tx_q      <= ie_tx_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
            rx_ack_q     <= rx_ack_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;
    assign cfg_options  = cfg_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign rx_ack       = rx_ack_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_ctrl
// Directed self-checking bench for uart_ctrl: a sender model answers tx_start
// with tx_done after 20 cycles, and a monitor records transmitted bytes,
// tx_start-low gaps between bytes and rx_ack pulses.
// ----------------------------------------------------------------------------
module tb_uart_ctrl;
    localparam int GAP = 16;
    localparam int DEPTH = 8;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       irq, tx_start, tx_done, rx_parity_ok, rx_ready, rx_busy, rx_ack;
    logic [7:0] cfg_options, tx_data, rx_data;
    logic       cts_n = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_ctrl_if bus ();

    uart_ctrl #(.TX_DEPTH(DEPTH), .GAP_CYCLES(GAP), .CFG_RESET(8'hC0)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .bus          (bus),
        .irq          (irq),
        .cfg_options  (cfg_options),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .rx_data      (rx_data),
        .rx_parity_ok (rx_parity_ok),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
`ifdef UART_CTS_EN
        .cts_n        (cts_n),
`endif
        .rx_ack       (rx_ack)
    );

    always #5 sys_clk = ~sys_clk;

    // Sender model: tx_done pulses on the 20th cycle tx_start is seen high.
    bit model_en = 1'b0;
    int start_age = 0;
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            tx_done = 1'b0;
            if (model_en && tx_start) begin
                start_age++;
                if (start_age == 20) tx_done = 1'b1;
            end else begin
                start_age = 0;
            end
        end
    end

    // Monitor sampled on the falling edge.
    logic [7:0] bytes[$];
    int         gaps[$];
    int         low_run = 0;
    int         ack_cnt = 0;
    bit         seen_first = 1'b0;
    logic       prev_start = 1'b0;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (tx_start === 1'b1 && prev_start !== 1'b1) begin
                bytes.push_back(tx_data);
                if (seen_first) gaps.push_back(low_run);
                seen_first = 1'b1;
            end
            if (tx_start === 1'b1) low_run = 0; else low_run++;
            prev_start = tx_start;
            if (rx_ack === 1'b1) ack_cnt++;
        end
    end

    task automatic mon_clear();
        bytes.delete();
        gaps.delete();
        seen_first = 1'b0;
        ack_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(posedge sys_clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.address = a; bus.read = 1'b1;
        @(posedge sys_clk); #1;
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic ok);
        rx_data = d; rx_parity_ok = ok; rx_ready = 1'b1;
        @(posedge sys_clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (rx_ack !== 1'b0) begin failures++; $display("FAIL reset_rx_ack got=%b exp=0", rx_ack); end
        checks++; if (cfg_options !== 8'hC0) begin failures++; $display("FAIL reset_cfg_options got=%02h exp=c0", cfg_options); end
        rd(3'd0, d);
        checks++; if (d !== 8'hC0) begin failures++; $display("FAIL reset_config got=%02h exp=c0", d); end
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL reset_status got=%02h exp=02", d); end
    endtask

    task automatic test_tx_burst();
        logic [7:0] d;
        int n;
        mon_clear();
        model_en = 1'b1;
        wr(3'd2, 8'h41); wr(3'd2, 8'h42); wr(3'd2, 8'h43);
        n = 0;
        while (bytes.size() < 3 && n < 400) begin cycles(1); n++; end
        checks++; if (bytes.size() != 3) begin failures++; $display("FAIL burst_timeout bytes=%0d exp=3", bytes.size()); end
        cycles(40);
        checks++; if (bytes.size() != 3) begin failures++; $display("FAIL burst_count got=%0d exp=3", bytes.size()); end
        for (int i = 0; i < 3 && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== 8'(8'h41 + i)) begin failures++; $display("FAIL burst_byte%0d got=%02h exp=%02h", i, bytes[i], 8'(8'h41 + i)); end
        end
        for (int i = 0; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] != GAP) begin failures++; $display("FAIL burst_gap%0d got=%0d exp=%0d", i, gaps[i], GAP); end
        end
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL burst_status_end got=%02h exp=02", d); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL burst_tx_start_end got=%b exp=0", tx_start); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d;
        int n;
        mon_clear();
        model_en = 1'b0;
        for (int i = 0; i < 10; i++) wr(3'd2, 8'(8'h10 + i));
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h10) begin failures++; $display("FAIL ovf_in_flight got start=%b data=%02h exp start=1 data=10", tx_start, tx_data); end
        rd(3'd1, d);
        checks++; if (d !== 8'h8C) begin failures++; $display("FAIL ovf_status got=%02h exp=8c", d); end
        wr(3'd1, 8'h80);
        rd(3'd1, d);
        checks++; if (d !== 8'h0C) begin failures++; $display("FAIL ovf_clear got=%02h exp=0c", d); end
        model_en = 1'b1;
        n = 0;
        while (bytes.size() < 9 && n < 1000) begin cycles(1); n++; end
        checks++; if (bytes.size() != 9) begin failures++; $display("FAIL ovf_drain_timeout bytes=%0d exp=9", bytes.size()); end
        cycles(60);
        checks++; if (bytes.size() != 9) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=9", bytes.size()); end
        for (int i = 0; i < 9 && i < bytes.size(); i++) begin
            checks++;
            if (bytes[i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovf_byte%0d got=%02h exp=%02h", i, bytes[i], 8'(8'h10 + i)); end
        end
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL ovf_status_end got=%02h exp=02", d); end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        mon_clear();
        rx_pulse(8'h55, 1'b1);
        cycles(1);
        rx_pulse(8'hAA, 1'b1);
        cycles(2);
        checks++; if (ack_cnt != 2) begin failures++; $display("FAIL rx_ack_count got=%0d exp=2", ack_cnt); end
        rd(3'd1, d);
        checks++; if (d !== 8'h23) begin failures++; $display("FAIL rx_ovr_status got=%02h exp=23", d); end
        rd(3'd3, d);
        checks++; if (d !== 8'h55) begin failures++; $display("FAIL rx_first_byte got=%02h exp=55", d); end
        wr(3'd1, 8'h20);
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL rx_cleared_status got=%02h exp=02", d); end
        rx_pulse(8'h3C, 1'b0);
        rd(3'd1, d);
        checks++; if (d !== 8'h13) begin failures++; $display("FAIL rx_parity_status got=%02h exp=13", d); end
        rd(3'd3, d);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL rx_parity_byte got=%02h exp=3c", d); end
        rx_pulse(8'h11, 1'b1);
        // RXDATA read and a new byte in the same cycle
        bus.address = 3'd3; bus.read = 1'b1;
        rx_data = 8'h22; rx_parity_ok = 1'b1; rx_ready = 1'b1;
        @(posedge sys_clk); #1;
        bus.read = 1'b0; rx_ready = 1'b0;
        checks++; if (bus.readdata !== 8'h11) begin failures++; $display("FAIL rx_same_cycle_old got=%02h exp=11", bus.readdata); end
        rd(3'd1, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL rx_same_cycle_status got=%02h exp=03", d); end
        rd(3'd3, d);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL rx_same_cycle_new got=%02h exp=22", d); end
    endtask

    task automatic test_cfg_lockout();
        logic [7:0] d;
        rx_busy = 1'b1;
        wr(3'd0, 8'h01);
        rx_busy = 1'b0;
        rd(3'd0, d);
        checks++; if (d !== 8'hC0) begin failures++; $display("FAIL cfg_locked got=%02h exp=c0", d); end
        rd(3'd1, d);
        checks++; if (d !== 8'h42) begin failures++; $display("FAIL cfg_err_status got=%02h exp=42", d); end
        wr(3'd1, 8'h40);
        wr(3'd0, 8'h01);
        rd(3'd0, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL cfg_accepted got=%02h exp=01", d); end
        checks++; if (cfg_options !== 8'h01) begin failures++; $display("FAIL cfg_options_port got=%02h exp=01", cfg_options); end
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL cfg_err_cleared got=%02h exp=02", d); end
        wr(3'd0, 8'hC0);
    endtask

    task automatic test_irq_reset();
        logic [7:0] d;
        wr(3'd4, 8'h01);
        rd(3'd4, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL irq_en_read got=%02h exp=01", d); end
        rx_pulse(8'h5A, 1'b1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_latency_early got=%b exp=0", irq); end
        cycles(1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx got=%b exp=1", irq); end
        model_en = 1'b0;
        wr(3'd2, 8'h77);
        cycles(2);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin failures++; $display("FAIL irq_send_state got start=%b data=%02h exp start=1 data=77", tx_start, tx_data); end
        reset = 1'b1;
        cycles(1);
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
        checks++; if (cfg_options !== 8'hC0) begin failures++; $display("FAIL mid_reset_cfg got=%02h exp=c0", cfg_options); end
        reset = 1'b0;
        mon_clear();
        model_en = 1'b1;
        cycles(60);
        checks++; if (bytes.size() != 0) begin failures++; $display("FAIL mid_reset_retry got=%0d bytes exp=0", bytes.size()); end
        rd(3'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL mid_reset_status got=%02h exp=02", d); end
        wr(3'd4, 8'h02);
        cycles(1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_idle got=%b exp=1", irq); end
        wr(3'd4, 8'h00);
        cycles(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", irq); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.address = 3'd0; bus.write = 1'b0; bus.writedata = 8'h00; bus.read = 1'b0;
        rx_data = 8'h00; rx_parity_ok = 1'b1; rx_ready = 1'b0; rx_busy = 1'b0;
        @(posedge sys_clk); #1;
        test_reset();
        test_tx_burst();
        test_tx_overflow();
        test_rx();
        test_cfg_lockout();
        test_irq_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Register-mapped controller between the host bus (Nios-side) and the UART datapath (configuration, receiver, sender).
- Holds the 8-bit UART configuration word and buffers outgoing bytes in a TX FIFO.
- Sequences the sender one byte at a time using a start/done handshake.
- Captures received bytes into a holding register, acknowledges the receiver, and raises an interrupt.

Parameters:
TX_DEPTH, 8, TX FIFO depth in bytes; power of two, minimum 2
GAP_CYCLES, 16, sys_clk cycles of idle inserted after each tx_done before the next byte starts; 0 means no gap
CFG_RESET, 8'b11000000, reset value of the configuration register

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
address  in  3  register select
write  in  1  write strobe, one cycle per access
writedata  in  8  write data
read  in  1  read strobe, one cycle per access
readdata  out  8  registered read data
irq  out  1  level interrupt
cfg_options  out  8  configuration word to clock decoders, parity checker and receiver
tx_data  out  8  byte presented to the sender
tx_start  out  1  send request; held until tx_done
tx_done  in  1  one-cycle pulse from the sender, sys_clk-synchronous
rx_data  in  8  received byte
rx_parity_ok  in  1  parity status for rx_data
rx_ready  in  1  one-cycle pulse: rx_data valid
rx_busy  in  1  receiver mid-frame
rx_ack  out  1  one-cycle acknowledge to the receiver (data_read)

Behaviour:
- Reset values: readdata 0, irq 0, cfg_options CFG_RESET, tx_data 0, tx_start 0, rx_ack 0. FIFO empty, TX state IDLE, all flags and enables 0.
- Register map (read / write):
  - 0 CONFIG: read cfg_options / write cfg_options.
  - 1 STATUS: read bits {7 tx_ovf, 6 cfg_err, 5 rx_ovr, 4 parity_err, 3 tx_busy, 2 tx_full, 1 tx_empty, 0 rx_valid} / write 1 to bits 7, 6 or 5 clears that flag; other bits ignored.
  - 2 TXDATA: read 0 / write pushes a byte to the FIFO.
  - 3 RXDATA: read returns the held byte and clears rx_valid / write ignored.
  - 4 IRQ_EN: read/write; bit0 ie_rx, bit1 ie_tx.
  - 5-7: read 0 / write ignored.
- Read latency: readdata is updated on the edge after the read strobe and holds until the next read.
- Simultaneous read and write in one cycle: both are performed; the read returns pre-write contents.
- CONFIG write is accepted only when TX state is IDLE, the FIFO is empty, tx_start is 0 and rx_busy is 0. Otherwise the write is discarded and cfg_err is set.
- TX FIFO:
  - Push when full: byte is discarded and tx_ovf is set. This applies even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO: both take effect.
  - Pointers wrap modulo TX_DEPTH. The count is log2(TX_DEPTH)+1 bits wide.
- TX FSM:
  - IDLE: if the FIFO is non-empty, pop the head into tx_data and go to SEND.
  - SEND: tx_start=1, tx_data stable. On tx_done, set tx_start=0 next edge and go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
  - tx_busy = (state != IDLE). tx_done outside SEND is ignored.
  - Latency from a TXDATA write into an empty idle FIFO to tx_start=1: 2 cycles.
- RX path, on rx_ready:
  - If rx_valid=0: capture rx_data, set parity_err = ~rx_parity_ok, set rx_valid.
  - If rx_valid=1: drop the byte, set rx_ovr.
  - rx_ack pulses one cycle later in both cases.
  - rx_ready in the same cycle as an RXDATA read: the read returns the old byte, the new byte is captured, rx_valid stays 1, no overrun.
- irq = (rx_valid & ie_rx) | (tx_empty & ~tx_busy & ie_tx), registered (one cycle latency).
- Reset mid-operation returns everything to reset values next edge:
  - tx_start drops immediately.
  - The FIFO is flushed.
  - The byte in flight is not retried.

Optional Feature:
UART_CTS_EN
- Defined: adds input port cts_n (1 bit, active-low clear-to-send, already synchronous). IDLE leaves for SEND only when cts_n=0. cts_n rising during SEND does not abort the current byte. STATUS bit7 becomes cts (=~cts_n) and tx_ovf moves to IRQ_EN bit7 read-only.
- Undefined: no port; transmission is gated only by FIFO state.

Test Plan:
- Reset: after reset, read CONFIG -> 8'hC0. Read STATUS -> 8'h02. irq=0, tx_start=0.
- TX burst: write TXDATA 8'h41, 8'h42, 8'h43; the model pulses tx_done 20 cycles after each tx_start.
  -> tx_data sequence 41, 42, 43.
  -> tx_start low exactly GAP_CYCLES cycles between bytes.
  -> FIFO empty afterwards.
- TX overflow: with tx_done withheld, push 10 bytes at TX_DEPTH=8.
  -> 1 byte in SEND and 8 in the FIFO; the 10th is dropped.
  -> STATUS bit7=1 and bit2=1. Writing 8'h80 to STATUS clears bit7.
- RX overrun and ack: pulse rx_ready with 8'h55, parity_ok=1, then 8'hAA before any read.
  -> RXDATA reads 8'h55. rx_ovr=1. Two rx_ack pulses seen.
  -> Same-cycle rx_ready plus RXDATA read: no rx_ovr.
- Config lockout: write CONFIG 8'h01 while rx_busy=1 -> CONFIG is still 8'hC0 and cfg_err=1. Repeat when idle -> CONFIG=8'h01.
- IRQ and reset: set ie_rx, deliver a byte -> irq=1 two cycles after rx_ready. Assert reset during SEND -> tx_start=0 and irq=0 next edge.
